// File: rtl/mc_control_ext_if.sv
// Control/status bundle between the multicycle MIPS controller (master)
// and the datapath it steers (slave).
interface mc_control_ext_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       pc_en;
    logic       branch;
    logic       branch_ne;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [3:0] state;
    logic       illegal;
    logic       mem_timeout;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output ir_write, pc_write, reg_write, mem_write, mem_read, pc_en,
               branch, branch_ne, alu_src_a, alu_src_b, alu_ctl, pc_src,
               reg_dst, mem_to_reg, state, illegal, mem_timeout
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ir_write, pc_write, reg_write, mem_write, mem_read, pc_en,
               branch, branch_ne, alu_src_a, alu_src_b, alu_ctl, pc_src,
               reg_dst, mem_to_reg, state, illegal, mem_timeout
    );
endinterface

// File: rtl/mc_control_ext.sv
// Multicycle MIPS main controller with wait-state memory, bne, imm-logical ops,
// memory watchdog and illegal flagging. Define MC_CONTROL_JAL_EN to build jal.
module mc_control_ext #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_ext_if.master dp_io
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IEXEC    = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11
`ifdef MC_CONTROL_JAL_EN
        , S_JAL    = 4'd12
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   count_q, count_d;

    logic       ir_wr, pc_wr, reg_wr, mem_wr, mem_rd;
    logic       br_eq, br_ne, src_a;
    logic [1:0] src_b, pc_src, reg_dst, mem_to_reg;
    logic [2:0] alu_ctl;
    logic       waiting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        illegal_d  = illegal_q;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        br_eq      = 1'b0;
        br_ne      = 1'b0;
        src_a      = 1'b0;
        src_b      = 2'b00;
        alu_ctl    = ALU_ADD;
        pc_src     = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_rd  = 1'b1;
                src_b   = 2'b01;
                ir_wr   = dp_io.mem_ready;
                pc_wr   = dp_io.mem_ready;
                state_d = dp_io.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                src_b = 2'b10;
                case (dp_io.opcode)
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_RTYPE:                state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
                    OP_J:                    state_d = S_JUMP;
`ifdef MC_CONTROL_JAL_EN
                    OP_JAL:                  state_d = S_JAL;
`endif
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                state_d = (dp_io.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_rd  = 1'b1;
                state_d = dp_io.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                mem_to_reg = 2'b01;
                reg_wr     = 1'b1;
            end
            S_MEMWRITE: begin
                mem_wr  = 1'b1;
                state_d = dp_io.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                src_a   = 1'b1;
                state_d = S_ALUWB;
                // Unknown funct still completes as an add so the pipeline of states stays uniform.
                case (dp_io.funct)
                    6'b100000: alu_ctl = ALU_ADD;
                    6'b100010: alu_ctl = ALU_SUB;
                    6'b100100: alu_ctl = ALU_AND;
                    6'b100101: alu_ctl = ALU_OR;
                    6'b101010: alu_ctl = ALU_SLT;
                    default:   illegal_d = 1'b1;
                endcase
            end
            S_ALUWB: begin
                reg_dst = 2'b01;
                reg_wr  = 1'b1;
            end
            S_BRANCH: begin
                src_a   = 1'b1;
                alu_ctl = ALU_SUB;
                pc_src  = 2'b01;
                br_eq   = (dp_io.opcode == OP_BEQ);
                br_ne   = (dp_io.opcode == OP_BNE);
            end
            S_IEXEC: begin
                src_a   = 1'b1;
                state_d = S_IMMWB;
                case (dp_io.opcode)
                    OP_ANDI: begin
                        src_b   = 2'b11;
                        alu_ctl = ALU_AND;
                    end
                    OP_ORI: begin
                        src_b   = 2'b11;
                        alu_ctl = ALU_OR;
                    end
                    default: src_b = 2'b10;
                endcase
            end
            S_IMMWB: reg_wr = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_wr  = 1'b1;
            end
`ifdef MC_CONTROL_JAL_EN
            S_JAL: begin
                pc_src     = 2'b10;
                pc_wr      = 1'b1;
                reg_wr     = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Watchdog only observes; a stalled access keeps waiting after the flag rises.
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                     && !dp_io.mem_ready;

    always_comb begin
        count_d   = '0;
        timeout_d = timeout_q;
        if ((TIMEOUT != 0) && waiting) begin
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
            if (count_q == CNT_LAST) begin
                timeout_d = 1'b1;
            end
        end
    end

    assign dp_io.ir_write    = ir_wr  & ~rst;
    assign dp_io.pc_write    = pc_wr  & ~rst;
    assign dp_io.reg_write   = reg_wr & ~rst;
    assign dp_io.mem_write   = mem_wr & ~rst;
    assign dp_io.mem_read    = mem_rd;
    assign dp_io.branch      = br_eq;
    assign dp_io.branch_ne   = br_ne;
    assign dp_io.pc_en       = (pc_wr & ~rst) | (br_eq & dp_io.zero) | (br_ne & ~dp_io.zero);
    assign dp_io.alu_src_a   = src_a;
    assign dp_io.alu_src_b   = src_b;
    assign dp_io.alu_ctl     = alu_ctl;
    assign dp_io.pc_src      = pc_src;
    assign dp_io.reg_dst     = reg_dst;
    assign dp_io.mem_to_reg  = mem_to_reg;
    assign dp_io.state       = state_q;
    assign dp_io.illegal     = illegal_q;
    assign dp_io.mem_timeout = timeout_q;
endmodule

// File: tb/tb_mc_control_ext.sv
// Directed testbench for mc_control_ext: per-cycle control words for each
// instruction class, illegal flagging, mid-access reset and the watchdog.
module tb_mc_control_ext;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    logic [23:0] F1, DEC, MA;

    mc_control_ext_if bus ();

    mc_control_ext #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .dp_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: state, {ir,pc,reg,memw,memr,pc_en,br,brne}, srcA, srcB, alu, pcsrc, regdst, memtoreg.
    function automatic logic [23:0] pack(input logic [3:0] st, input logic [7:0] en, input logic a,
                                         input logic [1:0] b, input logic [2:0] alu, input logic [1:0] ps,
                                         input logic [1:0] rd, input logic [1:0] mtr);
        return {st, en, a, b, alu, ps, rd, mtr};
    endfunction

    function automatic logic [23:0] observed();
        return pack(bus.state,
                    {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write,
                     bus.mem_read, bus.pc_en, bus.branch, bus.branch_ne},
                    bus.alu_src_a, bus.alu_src_b, bus.alu_ctl, bus.pc_src,
                    bus.reg_dst, bus.mem_to_reg);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b000000;
        bus.funct = 6'b100000;
        bus.zero = 1'b0;
        #1;
        tests++;
        if ({bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write} !== 4'b0000) begin
            failed++;
            $display("[TB] FAIL reset_force_writes: got %b, expected 0000",
                     {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write});
        end
        @(negedge clk);
        tests++;
        if ({bus.state, bus.illegal, bus.mem_timeout, bus.pc_write} !== 7'b0000_000) begin
            failed++;
            $display("[TB] FAIL reset_state: got %b, expected 0000000",
                     {bus.state, bus.illegal, bus.mem_timeout, bus.pc_write});
        end
        rst = 1'b0;
        #1;
        tests++;
        if (observed() !== F1) begin
            failed++;
            $display("[TB] FAIL reset_release_fetch: got %h, expected %h", observed(), F1);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0]  ac [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [23:0] exp [4];
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.opcode = 6'b000000;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.funct = fn[k];
            exp = '{F1, DEC, pack(4'd6, 8'h00, 1'b1, 2'b00, ac[k], 2'b00, 2'b00, 2'b00),
                    pack(4'd7, 8'b0010_0000, 1'b0, 2'b00, 3'b010, 2'b00, 2'b01, 2'b00)};
            for (int i = 0; i < 4; i++) begin
                #1;
                tests++;
                if (observed() !== exp[i]) begin
                    failed++;
                    $display("[TB] FAIL rtype funct=%b row %0d: got %h, expected %h", fn[k], i, observed(), exp[i]);
                end
                @(negedge clk);
            end
        end
        #1;
        tests++;
        if (bus.illegal !== 1'b0) begin
            failed++;
            $display("[TB] FAIL rtype_no_illegal: got %b, expected 0", bus.illegal);
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [23:0] exp [8];
        logic [23:0] mr;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.opcode = 6'b100011;
        mr = pack(4'd3, 8'b0000_1000, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00);
        exp = '{F1, DEC, MA, mr, mr, mr, mr,
                pack(4'd4, 8'b0010_0000, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b01)};
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            tests++;
            if (observed() !== exp[i]) begin
                failed++;
                $display("[TB] FAIL lw_wait row %0d: got %h, expected %h", i, observed(), exp[i]);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if ({bus.state, bus.mem_timeout} !== 5'b0000_0) begin
            failed++;
            $display("[TB] FAIL lw_done: got %b, expected 00000", {bus.state, bus.mem_timeout});
        end
    endtask

    task automatic test_sw_and_reset_mid();
        logic [23:0] exp [4];
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.opcode = 6'b101011;
        bus.mem_ready = 1'b1;
        exp = '{F1, DEC, MA, pack(4'd5, 8'b0001_0000, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00)};
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (observed() !== exp[i]) begin
                failed++;
                $display("[TB] FAIL sw row %0d: got %h, expected %h", i, observed(), exp[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        if ({bus.state, bus.mem_write} !== 5'b0101_1) begin
            failed++;
            $display("[TB] FAIL sw_stall: got %b, expected 01011", {bus.state, bus.mem_write});
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.mem_write !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_mid_write: got %b, expected 0", bus.mem_write);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.state !== 4'd0) begin
            failed++;
            $display("[TB] FAIL reset_mid_state: got %0d, expected 0", bus.state);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  op [4] = '{6'b000100, 6'b000101, 6'b000101, 6'b000100};
        logic        z  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0]  en [4] = '{8'b0000_0110, 8'b0000_0001, 8'b0000_0101, 8'b0000_0010};
        logic [23:0] exp [3];
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.opcode = op[k];
            bus.zero = z[k];
            exp = '{F1, DEC, pack(4'd8, en[k], 1'b1, 2'b00, 3'b110, 2'b01, 2'b00, 2'b00)};
            for (int i = 0; i < 3; i++) begin
                #1;
                tests++;
                if (observed() !== exp[i]) begin
                    failed++;
                    $display("[TB] FAIL branch op=%b zero=%b row %0d: got %h, expected %h", op[k], z[k], i, observed(), exp[i]);
                end
                @(negedge clk);
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_imm();
        logic [5:0]  op [3] = '{6'b001000, 6'b001100, 6'b001101};
        logic [1:0]  sb [3] = '{2'b10, 2'b11, 2'b11};
        logic [2:0]  ac [3] = '{3'b010, 3'b000, 3'b001};
        logic [23:0] exp [4];
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.opcode = op[k];
            exp = '{F1, DEC, pack(4'd9, 8'h00, 1'b1, sb[k], ac[k], 2'b00, 2'b00, 2'b00),
                    pack(4'd10, 8'b0010_0000, 1'b0, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00)};
            for (int i = 0; i < 4; i++) begin
                #1;
                tests++;
                if (observed() !== exp[i]) begin
                    failed++;
                    $display("[TB] FAIL imm op=%b row %0d: got %h, expected %h", op[k], i, observed(), exp[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jump();
        logic [23:0] exp [4];
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b000010;
        exp = '{F1, DEC, pack(4'd11, 8'b0100_0100, 1'b0, 2'b00, 3'b010, 2'b10, 2'b00, 2'b00), F1};
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (observed() !== exp[i]) begin
                failed++;
                $display("[TB] FAIL jump row %0d: got %h, expected %h", i, observed(), exp[i]);
            end
            @(negedge clk);
        end
    endtask

`ifdef MC_CONTROL_JAL_EN
    task automatic test_jal();
        logic [23:0] exp [4];
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b000011;
        exp = '{F1, DEC, pack(4'd12, 8'b0110_0100, 1'b0, 2'b00, 3'b010, 2'b10, 2'b10, 2'b10), F1};
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (observed() !== exp[i]) begin
                failed++;
                $display("[TB] FAIL jal row %0d: got %h, expected %h", i, observed(), exp[i]);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_illegal();
        logic [23:0] ex, wb;
        ex = pack(4'd6, 8'h00, 1'b1, 2'b00, 3'b010, 2'b00, 2'b00, 2'b00);
        wb = pack(4'd7, 8'b0010_0000, 1'b0, 2'b00, 3'b010, 2'b00, 2'b01, 2'b00);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b111111;
        bus.funct = 6'b100000;
        @(negedge clk);
        #1;
        tests++;
        if ({observed(), bus.illegal} !== {DEC, 1'b0}) begin
            failed++;
            $display("[TB] FAIL illegal_op_decode: got %h/%b, expected %h/0", observed(), bus.illegal, DEC);
        end
        @(negedge clk);
        bus.opcode = 6'b000000;
        bus.funct = 6'b000000;
        #1;
        tests++;
        if ({observed(), bus.illegal} !== {F1, 1'b1}) begin
            failed++;
            $display("[TB] FAIL illegal_op_set: got %h/%b, expected %h/1", observed(), bus.illegal, F1);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (observed() !== ex) begin
            failed++;
            $display("[TB] FAIL illegal_funct_exec: got %h, expected %h", observed(), ex);
        end
        @(negedge clk);
        #1;
        tests++;
        if ({observed(), bus.illegal} !== {wb, 1'b1}) begin
            failed++;
            $display("[TB] FAIL illegal_sticky_wb: got %h/%b, expected %h/1", observed(), bus.illegal, wb);
        end

        @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if ({bus.state, bus.illegal} !== 5'b0110_0) begin
            failed++;
            $display("[TB] FAIL illegal_funct_before: got %b, expected 01100", {bus.state, bus.illegal});
        end
        @(negedge clk);
        #1;
        tests++;
        if ({bus.state, bus.reg_write, bus.illegal} !== 6'b0111_11) begin
            failed++;
            $display("[TB] FAIL illegal_funct_after: got %b, expected 011111", {bus.state, bus.reg_write, bus.illegal});
        end

`ifndef MC_CONTROL_JAL_EN
        @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.opcode = 6'b000011;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if ({bus.state, bus.illegal, bus.reg_write} !== 6'b0000_10) begin
            failed++;
            $display("[TB] FAIL jal_disabled_illegal: got %b, expected 000010", {bus.state, bus.illegal, bus.reg_write});
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic exp_to;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct = 6'b100000;
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_to = (k >= 4);
            #1;
            tests++;
            if ({bus.state, bus.mem_timeout} !== {4'd0, exp_to}) begin
                failed++;
                $display("[TB] FAIL timeout after %0d waits: got %b, expected %b", k, {bus.state, bus.mem_timeout}, {4'd0, exp_to});
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (bus.mem_timeout !== 1'b1) begin
            failed++;
            $display("[TB] FAIL timeout after 6 waits: got %b, expected 1", bus.mem_timeout);
        end
        bus.mem_ready = 1'b1;
        #1;
        tests++;
        if (bus.ir_write !== 1'b1) begin
            failed++;
            $display("[TB] FAIL timeout_fetch_completes: got %b, expected 1", bus.ir_write);
        end
        @(negedge clk);
        #1;
        tests++;
        if ({bus.state, bus.mem_timeout} !== 5'b0001_1) begin
            failed++;
            $display("[TB] FAIL timeout_decode_sticky: got %b, expected 00011", {bus.state, bus.mem_timeout});
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        #1;
        tests++;
        if (bus.mem_timeout !== 1'b0) begin
            failed++;
            $display("[TB] FAIL timeout_reset_clear: got %b, expected 0", bus.mem_timeout);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        F1  = pack(4'd0, 8'b1100_1100, 1'b0, 2'b01, 3'b010, 2'b00, 2'b00, 2'b00);
        DEC = pack(4'd1, 8'b0000_0000, 1'b0, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00);
        MA  = pack(4'd2, 8'b0000_0000, 1'b1, 2'b10, 3'b010, 2'b00, 2'b00, 2'b00);
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_and_reset_mid();
        test_branch();
        test_imm();
        test_jump();
`ifdef MC_CONTROL_JAL_EN
        test_jal();
`endif
        test_illegal();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/mc_control_ext.md
# mc_control_ext

Multicycle MIPS main controller, the successor to the current fixed-latency control FSM. It drives the existing multicycle datapath: PC, IR, register file, ALU, ALUOut, and the 3:1 PC-source mux. It adds wait-state memory handshaking, immediate-logical ops, `bne`, an optional `jal`, a memory-timeout watchdog, and illegal-instruction flagging.

## Interface
- `TIMEOUT`, default 0: wait-cycle limit on `mem_ready`; 0 disables the watchdog.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: the instruction or data memory access completes this cycle.
- `ir_write`, `pc_write`, `reg_write`, `mem_write`, `mem_read` out 1: datapath enables.
- `pc_en` out 1: `pc_write | (branch & zero) | (branch_ne & ~zero)`.
- `branch`, `branch_ne` out 1: conditional-branch qualifiers.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = constant 1, 10 = SignImm, 11 = ZeroImm.
- `alu_ctl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `reg_dst` out 2: 00 = rt, 01 = rd, 10 = r31.
- `mem_to_reg` out 2: 00 = ALUOut, 01 = Data, 10 = PC.
- `state` out 4: current state encoding, for debug.
- `illegal` out 1: sticky; set on an undefined opcode or funct.
- `mem_timeout` out 1: sticky; set when the watchdog expires.

## Operation
State encodings and actions (unlisted outputs are 0):
- FETCH=0: `mem_read`; `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00. `ir_write` and `pc_write` = `mem_ready`. Stays in FETCH while `mem_ready`=0; goes to DECODE on `mem_ready`=1.
- DECODE=1: `alu_src_a`=0, `alu_src_b`=10, add (branch target into ALUOut). Dispatch on `opcode`:
  - 100011 / 101011 → MEMADR
  - 000000 → EXECUTE
  - 000100 / 000101 → BRANCH
  - 001000 / 001100 / 001101 → IEXEC
  - 000010 → JUMP
  - 000011 → JAL (configurable, see Configuration)
  - any other opcode → FETCH, setting `illegal`.
- MEMADR=2: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD=3: `mem_read`; holds until `mem_ready`, then goes to MEMWB.
- MEMWB=4: `reg_dst`=00, `mem_to_reg`=01, `reg_write` → FETCH.
- MEMWRITE=5: `mem_write` held until `mem_ready`, then goes to FETCH.
- EXECUTE=6: `alu_src_a`=1, `alu_src_b`=00. `funct` maps to `alu_ctl`:
  - 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - Any other `funct` sets `illegal`, drives add, and the instruction still completes.
  - Next state: ALUWB.
- ALUWB=7: `reg_dst`=01, `mem_to_reg`=00, `reg_write` → FETCH.
- BRANCH=8: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01. `branch`=1 for 000100; `branch_ne`=1 for 000101. → FETCH.
- IEXEC=9: `alu_src_a`=1.
  - addi: `alu_src_b`=10, add.
  - andi: `alu_src_b`=11, and.
  - ori: `alu_src_b`=11, or.
  - Next state: IMMWB.
- IMMWB=10: `reg_dst`=00, `mem_to_reg`=00, `reg_write` → FETCH.
- JUMP=11: `pc_src`=10, `pc_write` → FETCH.
- JAL=12: `pc_src`=10, `pc_write`, `reg_write`, `reg_dst`=10, `mem_to_reg`=10. Writes r31 with the pre-update PC (already PC+1). → FETCH.
- Codes 13–15 are unreachable; if entered, go to FETCH.

Watchdog (TIMEOUT>0):
- A counter increments each cycle the FSM is in FETCH, MEMREAD or MEMWRITE with `mem_ready`=0.
- It clears on `mem_ready`=1 or on leaving these states.
- When the count reaches TIMEOUT, `mem_timeout` is set. The FSM keeps waiting; it never aborts an access.

## Timing
- Reset: on the edge with `rst`=1, the FSM goes to FETCH and `illegal`, `mem_timeout` and the counter are cleared.
  - While `rst`=1, `pc_write`, `ir_write`, `reg_write` and `mem_write` are forced to 0 combinationally.
  - Reset mid-access abandons the access with no write.
- Outputs are Moore decodes of `state`/`opcode`/`funct`. Exceptions: `ir_write`/`pc_write` in FETCH are gated by `mem_ready`, and `pc_en` depends on `zero`.
- Latency with `mem_ready` tied to 1:
  - R-type, addi/andi/ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne, j, jal: 3 cycles.
  - Each `mem_ready`=0 cycle adds 1.
- `opcode` and `funct` must be stable from DECODE until the return to FETCH. The IR only loads in FETCH, so this holds.
- `illegal` is set on the edge leaving DECODE or EXECUTE.
- An undefined opcode costs 2 cycles and produces no write.

## Configuration
- `MC_CONTROL_JAL_EN` defined: opcode 000011 goes to JAL, as above.
- `MC_CONTROL_JAL_EN` undefined: 000011 is treated as undefined (`illegal` set, back to FETCH). State 12 is not built, and `reg_dst`/`mem_to_reg` never drive 10.

## Test plan
- Reset, then add r3=r1+r2 (r1=5, r2=7) with `mem_ready`=1 → states 0,1,6,7; `reg_write` in cycle 4 with `reg_dst`=01; r3=12; `pc_en` pulses only in FETCH.
- lw with `mem_ready` low for 3 cycles in MEMREAD → MEMREAD is held 4 cycles; `reg_write` with `mem_to_reg`=01 occurs once; total 8 cycles.
- beq with `zero`=1, then bne with `zero`=1 → `pc_en`=1, `pc_src`=01 for beq; `pc_en`=0 for bne.
- ori with imm 0xFFFF → `alu_src_b`=11, `alu_ctl`=001.
- opcode 111111, then R-type with funct 000000 → `illegal` set after DECODE and stays high; no `reg_write` for 111111; the R-type still writes back.
- TIMEOUT=4 with `mem_ready` low for 6 cycles in FETCH → `mem_timeout` rises on the 4th wait cycle; fetch completes when `mem_ready` rises.
- With `MC_CONTROL_JAL_EN`: jal at PC=9 → r31=10; `pc_src`=10.
